// File: rtl/nn_row_loader.sv
// DMA-to-image-buffer row loader: reads WPR DMA words per row, packs them LSW-first
// and writes each completed row into a ring of image-buffer rows.
module nn_row_loader #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ROW_NUM         = 6,
  parameter int unsigned DMA_DATA_WIDTH  = 16,
  parameter int unsigned DMA_ADDR_WIDTH  = 10,
  parameter int unsigned IMEM_ADDR_WIDTH = 10,
  parameter int unsigned ROW_DATA_WIDTH  = DATA_WIDTH * ROW_NUM,
  parameter int unsigned WPR             = ROW_DATA_WIDTH / DMA_DATA_WIDTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [DMA_ADDR_WIDTH-1:0]  i_src_base,
  input  logic [DMA_ADDR_WIDTH-1:0]  i_src_pitch,
  input  logic [IMEM_ADDR_WIDTH-1:0] i_row_cnt,
  input  logic [IMEM_ADDR_WIDTH-1:0] i_dst_base,
  input  logic [IMEM_ADDR_WIDTH-1:0] i_dst_depth,
  input  logic                       i_dma_rd_gnt,
  input  logic [DMA_DATA_WIDTH-1:0]  i_dma_rd_data,
  output logic                       o_dma_rd_en,
  output logic [DMA_ADDR_WIDTH-1:0]  o_dma_rd_addr,
  output logic                       o_img_bf_wr_en,
  output logic [IMEM_ADDR_WIDTH-1:0] o_img_bf_wr_addr,
  output logic [ROW_DATA_WIDTH-1:0]  o_img_bf_wr_data,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int unsigned WW = (WPR > 1) ? $clog2(WPR) : 1;
  localparam logic [WW-1:0]              LAST_W = WW'(WPR - 1);
  localparam logic [WW-1:0]              ONE_W  = WW'(1);
  localparam logic [IMEM_ADDR_WIDTH-1:0] ONE_I  = IMEM_ADDR_WIDTH'(1);
  localparam logic [DMA_ADDR_WIDTH-1:0]  ONE_A  = DMA_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [DMA_ADDR_WIDTH-1:0]  src_pitch_q, src_pitch_d;
  logic [DMA_ADDR_WIDTH-1:0]  row_addr_q, row_addr_d;
  logic [DMA_ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [IMEM_ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [IMEM_ADDR_WIDTH-1:0] dst_base_q, dst_base_d;
  logic [IMEM_ADDR_WIDTH-1:0] dst_depth_q, dst_depth_d;
  logic [IMEM_ADDR_WIDTH-1:0] rd_row_q, rd_row_d;
  logic [IMEM_ADDR_WIDTH-1:0] cap_row_q, cap_row_d;
  logic [IMEM_ADDR_WIDTH-1:0] off_q, off_d;
  logic [IMEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WW-1:0]              rd_w_q, rd_w_d;
  logic [WW-1:0]              cap_w_q, cap_w_d;
  logic [ROW_DATA_WIDTH-1:0]  pack_q, pack_d;
  logic [ROW_DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                       rd_en_q, rd_en_d;
  logic                       rd_vld_q, rd_vld_d;
  logic                       wr_en_q, wr_en_d;
  logic                       wr_last_q, wr_last_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  always_comb begin
    state_d     = state_q;
    src_pitch_d = src_pitch_q;
    row_addr_d  = row_addr_q;
    rd_addr_d   = rd_addr_q;
    row_cnt_d   = row_cnt_q;
    dst_base_d  = dst_base_q;
    dst_depth_d = dst_depth_q;
    rd_row_d    = rd_row_q;
    cap_row_d   = cap_row_q;
    off_d       = off_q;
    wr_addr_d   = wr_addr_q;
    rd_w_d      = rd_w_q;
    cap_w_d     = cap_w_q;
    pack_d      = pack_q;
    wr_data_d   = wr_data_q;
    rd_en_d     = rd_en_q;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_last_d   = 1'b0;
    done_d      = 1'b0;
    // rd_vld_q marks that i_dma_rd_data carries the word granted last cycle
    rd_vld_d    = rd_en_q & i_dma_rd_gnt;

    if (rd_vld_q) begin
      for (int unsigned i = 0; i < WPR; i++) begin
        if (cap_w_q == WW'(i)) begin
          pack_d[i*DMA_DATA_WIDTH +: DMA_DATA_WIDTH] = i_dma_rd_data;
        end
      end
      if (cap_w_q == LAST_W) begin
        wr_en_d   = 1'b1;
        wr_data_d = pack_d;
        wr_addr_d = dst_base_q + off_q;
        wr_last_d = (cap_row_q == row_cnt_q - ONE_I);
        off_d     = ((dst_depth_q != '0) && (off_q == dst_depth_q - ONE_I)) ? '0 : off_q + ONE_I;
        cap_w_d   = '0;
        cap_row_d = cap_row_q + ONE_I;
      end else begin
        cap_w_d = cap_w_q + ONE_W;
      end
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_row_cnt != '0) begin
            src_pitch_d = i_src_pitch;
            row_cnt_d   = i_row_cnt;
            dst_base_d  = i_dst_base;
            dst_depth_d = i_dst_depth;
            row_addr_d  = i_src_base;
            rd_addr_d   = i_src_base;
            rd_row_d    = '0;
            rd_w_d      = '0;
            cap_row_d   = '0;
            cap_w_d     = '0;
            off_d       = '0;
            rd_en_d     = 1'b1;
            busy_d      = 1'b1;
            state_d     = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (i_dma_rd_gnt) begin
          if (rd_w_q == LAST_W) begin
            if (rd_row_q == row_cnt_q - ONE_I) begin
              rd_en_d = 1'b0;
              state_d = DRAIN;
            end else begin
              row_addr_d = row_addr_q + src_pitch_q;
              rd_addr_d  = row_addr_q + src_pitch_q;
              rd_row_d   = rd_row_q + ONE_I;
              rd_w_d     = '0;
            end
          end else begin
            rd_addr_d = rd_addr_q + ONE_A;
            rd_w_d    = rd_w_q + ONE_W;
          end
        end
      end
      DRAIN: begin
        if (wr_last_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      src_pitch_q <= '0;
      row_addr_q  <= '0;
      rd_addr_q   <= '0;
      row_cnt_q   <= '0;
      dst_base_q  <= '0;
      dst_depth_q <= '0;
      rd_row_q    <= '0;
      cap_row_q   <= '0;
      off_q       <= '0;
      wr_addr_q   <= '0;
      rd_w_q      <= '0;
      cap_w_q     <= '0;
      pack_q      <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_pitch_q <= src_pitch_d;
      row_addr_q  <= row_addr_d;
      rd_addr_q   <= rd_addr_d;
      row_cnt_q   <= row_cnt_d;
      dst_base_q  <= dst_base_d;
      dst_depth_q <= dst_depth_d;
      rd_row_q    <= rd_row_d;
      cap_row_q   <= cap_row_d;
      off_q       <= off_d;
      wr_addr_q   <= wr_addr_d;
      rd_w_q      <= rd_w_d;
      cap_w_q     <= cap_w_d;
      pack_q      <= pack_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_vld_q    <= rd_vld_d;
      wr_en_q     <= wr_en_d;
      wr_last_q   <= wr_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_dma_rd_en      = rd_en_q;
  assign o_dma_rd_addr    = rd_addr_q;
  assign o_img_bf_wr_en   = wr_en_q;
  assign o_img_bf_wr_addr = wr_addr_q;
  assign o_img_bf_wr_data = wr_data_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;

endmodule

// File: tb/tb_nn_row_loader.sv
// Bench for nn_row_loader: a cycle-indexed transaction model predicts every output,
// a DMA responder returns data=addr, and a negedge process compares each cycle.
module tb_nn_row_loader;

  localparam int AW   = 10;
  localparam int IW   = 10;
  localparam int DW   = 16;
  localparam int RW   = 48;
  localparam int WPR  = 3;
  localparam int MAXC = 64;

  logic          i_clk = 1'b0;
  logic          i_rst, i_start, i_dma_rd_gnt;
  logic [AW-1:0] i_src_base, i_src_pitch;
  logic [IW-1:0] i_row_cnt, i_dst_base, i_dst_depth;
  logic [DW-1:0] i_dma_rd_data;
  logic          o_dma_rd_en, o_img_bf_wr_en, o_busy, o_done;
  logic [AW-1:0] o_dma_rd_addr;
  logic [IW-1:0] o_img_bf_wr_addr;
  logic [RW-1:0] o_img_bf_wr_data;

  always #5 i_clk = ~i_clk;

  nn_row_loader #(
    .DATA_WIDTH(8), .ROW_NUM(6), .DMA_DATA_WIDTH(DW),
    .DMA_ADDR_WIDTH(AW), .IMEM_ADDR_WIDTH(IW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_src_base(i_src_base), .i_src_pitch(i_src_pitch), .i_row_cnt(i_row_cnt),
    .i_dst_base(i_dst_base), .i_dst_depth(i_dst_depth),
    .i_dma_rd_gnt(i_dma_rd_gnt), .i_dma_rd_data(i_dma_rd_data),
    .o_dma_rd_en(o_dma_rd_en), .o_dma_rd_addr(o_dma_rd_addr),
    .o_img_bf_wr_en(o_img_bf_wr_en), .o_img_bf_wr_addr(o_img_bf_wr_addr),
    .o_img_bf_wr_data(o_img_bf_wr_data), .o_busy(o_busy), .o_done(o_done)
  );

  // DMA responder: a granted read returns its own address one cycle later
  always @(posedge i_clk)
    i_dma_rd_data <= (o_dma_rd_en && i_dma_rd_gnt) ? DW'(o_dma_rd_addr) : 16'hDEAD;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic          exp_rd_en[MAXC], exp_wr_en[MAXC], exp_busy[MAXC], exp_done[MAXC], exp_zero[MAXC];
  logic [AW-1:0] exp_rd_addr[MAXC];
  logic [IW-1:0] exp_wr_addr[MAXC];
  logic [RW-1:0] exp_wr_data[MAXC];
  bit            gnt_pat[MAXC];

  bit            chk_en  = 1'b0;
  int            cur_cyc = 0;
  int            done_cyc;
  logic [AW-1:0] rd_log[$];
  logic [IW-1:0] wr_log[$];

  task automatic clear_cycle(input int i);
    exp_rd_en[i] = 1'b0; exp_wr_en[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
    exp_rd_addr[i] = '0; exp_wr_addr[i] = '0; exp_wr_data[i] = '0;
  endtask

  // Walks the transfer word by word over cycles 1.. using the grant pattern
  task automatic build_model(input logic [AW-1:0] base, input logic [AW-1:0] pitch,
                             input logic [IW-1:0] rows, input logic [IW-1:0] dbase,
                             input logic [IW-1:0] depth, input int rst_at, output int last);
    int t, r, w, off, lastw;
    logic [AW-1:0] a;
    logic [RW-1:0] row;
    for (int i = 0; i < MAXC; i++) begin
      clear_cycle(i);
      exp_zero[i] = 1'b0;
    end
    if (rows == '0) begin
      exp_done[1] = 1'b1;
      last = 3;
      return;
    end
    t = 1; r = 0; w = 0; off = 0; lastw = 0; row = '0;
    while (r < int'(rows) && t < MAXC - 4) begin
      a = AW'(int'(base) + r * int'(pitch) + w);
      exp_rd_en[t] = 1'b1; exp_rd_addr[t] = a; exp_busy[t] = 1'b1;
      if (gnt_pat[t]) begin
        row[w*DW +: DW] = DW'(a);
        if (w == WPR - 1) begin
          exp_wr_en[t+2]   = 1'b1;
          exp_wr_addr[t+2] = IW'(int'(dbase) + off);
          exp_wr_data[t+2] = row;
          off   = (depth != '0 && off == int'(depth) - 1) ? 0 : off + 1;
          lastw = t + 2;
          w = 0;
          r++;
        end else begin
          w++;
        end
      end
      t++;
    end
    for (int i = 1; i <= lastw; i++) exp_busy[i] = 1'b1;
    exp_done[lastw+1] = 1'b1;
    last = lastw + 3;
    if (rst_at > 0) begin
      for (int i = rst_at + 1; i < MAXC; i++) begin
        clear_cycle(i);
        exp_zero[i] = 1'b1;
      end
      last = rst_at + 3;
    end
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk($sformatf("rd_en@%0d", cur_cyc), o_dma_rd_en, exp_rd_en[cur_cyc]);
      if (exp_rd_en[cur_cyc] || exp_zero[cur_cyc])
        chk($sformatf("rd_addr@%0d", cur_cyc), o_dma_rd_addr, exp_rd_addr[cur_cyc]);
      chk($sformatf("wr_en@%0d", cur_cyc), o_img_bf_wr_en, exp_wr_en[cur_cyc]);
      if (exp_wr_en[cur_cyc] || exp_zero[cur_cyc]) begin
        chk($sformatf("wr_addr@%0d", cur_cyc), o_img_bf_wr_addr, exp_wr_addr[cur_cyc]);
        chk($sformatf("wr_data@%0d", cur_cyc), o_img_bf_wr_data, exp_wr_data[cur_cyc]);
      end
      chk($sformatf("busy@%0d", cur_cyc), o_busy, exp_busy[cur_cyc]);
      chk($sformatf("done@%0d", cur_cyc), o_done, exp_done[cur_cyc]);
      if (o_dma_rd_en && i_dma_rd_gnt) rd_log.push_back(o_dma_rd_addr);
      if (o_img_bf_wr_en) wr_log.push_back(o_img_bf_wr_addr);
      if (o_done) done_cyc = cur_cyc;
    end
  end

  task automatic run_xfer(input logic [AW-1:0] base, input logic [AW-1:0] pitch,
                          input logic [IW-1:0] rows, input logic [IW-1:0] dbase,
                          input logic [IW-1:0] depth, input int restart_at, input int rst_at);
    int last;
    build_model(base, pitch, rows, dbase, depth, rst_at, last);
    rd_log.delete();
    wr_log.delete();
    done_cyc = -1;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_src_base = base; i_src_pitch = pitch; i_row_cnt = rows;
    i_dst_base = dbase; i_dst_depth = depth; i_dma_rd_gnt = gnt_pat[0];
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_src_base = ~base; i_src_pitch = ~pitch; i_row_cnt = ~rows;
    i_dst_base = ~dbase; i_dst_depth = ~depth;
    for (int t = 1; t <= last; t++) begin
      cur_cyc      = t;
      chk_en       = 1'b1;
      i_dma_rd_gnt = gnt_pat[t];
      i_start      = (t == restart_at);
      i_rst        = (t == rst_at);
      if (t == restart_at) begin
        i_src_base = 10'h2AA; i_row_cnt = 10'd1; i_dst_base = 10'h155;
      end
      @(posedge i_clk); #1;
    end
    chk_en  = 1'b0;
    i_start = 1'b0;
    i_rst   = 1'b0;
  endtask

  logic [AW-1:0] pitch_exp[9] = '{10'd0, 10'd1, 10'd2, 10'd8, 10'd9, 10'd10, 10'd16, 10'd17, 10'd18};
  logic [IW-1:0] ring_exp[6]  = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h3FE, 10'h3FF};

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_dma_rd_gnt = 1'b0;
    i_src_base = '0; i_src_pitch = '0; i_row_cnt = '0; i_dst_base = '0; i_dst_depth = '0;
    for (int i = 0; i < MAXC; i++) gnt_pat[i] = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset rd_en", o_dma_rd_en, 1'b0);
    chk("reset rd_addr", o_dma_rd_addr, '0);
    chk("reset wr_en", o_img_bf_wr_en, 1'b0);
    chk("reset wr_addr", o_img_bf_wr_addr, '0);
    chk("reset wr_data", o_img_bf_wr_data, '0);
    chk("reset busy", o_busy, 1'b0);
    chk("reset done", o_done, 1'b0);
    i_rst = 1'b0;

    // basic load, with an ignored start request in cycle 3
    run_xfer(10'h010, 10'd3, 10'd2, 10'd5, 10'd0, 3, 0);
    chk("model row0 data", exp_wr_data[5], 48'h0012_0011_0010);
    chk("model row0 addr", exp_wr_addr[5], 10'd5);
    chk("model row1 data", exp_wr_data[8], 48'h0015_0014_0013);
    chk("model row1 addr", exp_wr_addr[8], 10'd6);
    chk("basic done cycle", done_cyc, 9);
    chk("basic writes", wr_log.size(), 2);

    run_xfer(10'd0, 10'd8, 10'd3, 10'd0, 10'd0, 0, 0);
    chk("pitch reads", rd_log.size(), 9);
    for (int i = 0; i < 9 && i < rd_log.size(); i++)
      chk($sformatf("pitch read %0d", i), rd_log[i], pitch_exp[i]);

    run_xfer(10'd0, 10'd3, 10'd6, 10'h3FE, 10'd4, 0, 0);
    chk("ring writes", wr_log.size(), 6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++)
      chk($sformatf("ring addr %0d", i), wr_log[i], ring_exp[i]);

    gnt_pat[2] = 1'b0;
    gnt_pat[3] = 1'b0;
    run_xfer(10'h010, 10'd3, 10'd2, 10'd5, 10'd0, 0, 0);
    gnt_pat[2] = 1'b1;
    gnt_pat[3] = 1'b1;
    chk("stall model row0 data", exp_wr_data[7], 48'h0012_0011_0010);
    chk("stall done cycle", done_cyc, 11);

    run_xfer(10'h010, 10'd3, 10'd0, 10'd5, 10'd0, 0, 0);
    chk("zero-row done cycle", done_cyc, 1);
    chk("zero-row reads", rd_log.size(), 0);

    run_xfer(10'h010, 10'd3, 10'd2, 10'd5, 10'd0, 0, 5);
    chk("reset-mid writes", wr_log.size(), 1);
    chk("reset-mid no done", done_cyc, -1);

    run_xfer(10'h010, 10'd3, 10'd2, 10'd5, 10'd0, 0, 0);
    chk("post-reset done cycle", done_cyc, 9);
    chk("post-reset writes", wr_log.size(), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
